window_addr_gen: RTL
====================

# window_addr_gen

Parametrised 3x3 convolution-window address generator for the image-processing engine. It latches N_ORIG window-centre pixel indices on a start pulse, then walks every depth plane, every origin and all nine kernel taps. For each tap it issues a flat buffer address and an effective bit (0 means zero-padding). Unlike the fixed 8x8/4-origin generator, it adds arbitrary power-of-two image geometry, valid/ready back-pressure, a busy/done handshake and an optional dilation-2 window.

## Interface
Parameters:
- COL_W, 3: log2 image width (columns)
- ROW_W, 3: log2 image height (rows)
- DEP_W, 2: log2 number of depth planes
- N_ORIG, 4: origins per start (≥1)
- PIX_W (derived), ROW_W+COL_W: origin/pixel index width
- ADDR_W (derived), DEP_W+PIX_W: address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- depth_all  in  1  1: scan depths 0..2^DEP_W-1; 0: last depth only
- dilate  in  1  1: dilation-2 taps (only with macro; otherwise ignored)
- origin_i  in  N_ORIG*PIX_W  origin k at bits [k*PIX_W +: PIX_W], as {row,col}
- addr_o  out  ADDR_W  {depth,row,col} of current tap
- eff_o  out  1  tap inside image
- tap_o  out  4  tap index 0..8, row-major (0 = up-left, 4 = centre)
- valid_o  out  1  addr_o/eff_o/tap_o valid
- ready_i  in  1  consumer accepts the tap
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse after the last tap handshake

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1. In the same edge: latch origin_i, depth_all and dilate; set tap=0, org=0, depth = depth_all ? 0 : 2^DEP_W-1.
- RUN: valid_o=1. A tap advances only on a handshake (valid_o & ready_i).
- Loop order: tap is innermost (0..8), then org (0..N_ORIG-1), then depth.
- After the handshake of the last tap (tap 8, org N_ORIG-1, depth 2^DEP_W-1): RUN → DONE.
- DONE → IDLE unconditionally; done_o=1 for that single cycle.
- Tap offset: dr,dc ∈ {-1,0,+1} × D, with D=2 if dilate else 1.
- Row/column arithmetic is signed, one bit wider than ROW_W/COL_W; no wrap-around.
- eff_o = 1 only if 0 ≤ row+dr < 2^ROW_W and 0 ≤ col+dc < 2^COL_W.
- If eff_o=1: addr_o = {depth, row+dr, col+dc}. If eff_o=0: addr_o forced to 0.
- Taps per start: N_ORIG*9 with depth_all=0; N_ORIG*9*2^DEP_W with depth_all=1.
- start while busy is ignored; start in DONE is ignored.
- ready_i outside RUN is ignored.

## Timing
- All outputs are registered. Reset value 0 for addr_o, eff_o, tap_o, valid_o, busy_o, done_o; state = IDLE.
- Latency: start sampled at edge n gives valid_o=1 with tap 0 from edge n.
- busy_o = 1 from edge n until the DONE→IDLE edge.
- With ready_i held high: one tap per cycle, no bubbles between origins or depths.
- valid_o & !ready_i: addr_o, eff_o and tap_o hold stable.
- done_o asserts the cycle after the final handshake. valid_o=0 in that cycle.
- rst_n asserted mid-sequence: immediate return to IDLE with all outputs 0. No done_o pulse.

## Configuration
- WINDOW_DILATION_EN defined: the dilate port is honoured, D ∈ {1,2}.
- WINDOW_DILATION_EN undefined: the dilate port exists but is unused, D fixed at 1, and the dilation comparators are not built.

## Structure
- Package win_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - TAP_DR / TAP_DC constant arrays for the nine offsets (−1/0/+1)
  - TAP_LAST = 8
- Sub-module window_tap_calc is combinational. Inputs: origin, tap, depth, D. Outputs: address and effective bit. It is instantiated once and fed from the muxed current origin.

## Test plan
Defaults unless stated: COL_W=ROW_W=3, DEP_W=2, N_ORIG=4, ready_i=1.
- Corner origin: origins {0,27,63,7}, depth_all=0, dilate=0.
  - Origin 0: eff on taps 0..8 = 0,0,0,0,1,1,0,1,1.
  - Origin 0 addresses: tap4 = 192, tap5 = 193, tap7 = 200, tap8 = 201. Every eff=0 tap has addr_o = 0.
- Interior and far corner, same run:
  - Origin 27: taps 0..8 = 210,211,212,218,219,220,226,227,228, all eff=1.
  - Origin 63: taps 2,5,6,7,8 have eff=0.
- Count/done: depth_all=1.
  - Exactly 144 handshakes with depth 0,0,..,3 ascending.
  - Single done_o one cycle after the last tap; busy_o falls on the same edge.
- Back-pressure: ready_i=0 for 3 cycles while tap_o=4 of origin 1.
  - addr_o/eff_o/tap_o stable throughout; next handshake presents tap 5.
  - Total handshakes remain 36.
- Dilation (macro on): origin 27, dilate=1, depth_all=0.
  - Tap0 addr = 201 (row1, col1); tap8 = 237.
  - Origin 1: tap3 eff=0. With the macro off, the same stimulus yields tap0 = 210.
- Reset and start misuse:
  - rst_n low at handshake 20: all outputs 0 next cycle, no done_o.
  - After release, start runs a full sequence.
  - start pulsed mid-RUN has no effect on the count.

Source files
------------

// File: rtl/win_pkg.sv
// win_pkg: FSM state encoding and 3x3 tap offset tables shared by window_addr_gen.
package win_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [3:0] TAP_LAST = 4'd8;
    localparam logic [1:0] TAP_DR [9] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    localparam logic [1:0] TAP_DC [9] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
endpackage

// File: rtl/window_tap_calc.sv
// window_tap_calc: combinational address/effective-bit for one 3x3 tap of one origin.
// Dilation-2 offsets are only built with WINDOW_DILATION_EN defined.
module window_tap_calc
    import win_pkg::*;
#(
    parameter int COL_W = 3,
    parameter int ROW_W = 3,
    parameter int DEP_W = 2
) (
    input  logic [ROW_W+COL_W-1:0]       origin,
    input  logic [3:0]                   tap,
    input  logic [DEP_W-1:0]             depth,
    input  logic                         dil,
    output logic [DEP_W+ROW_W+COL_W-1:0] addr,
    output logic                         eff
);
    logic [ROW_W:0] dr, r;
    logic [COL_W:0] dc, c;
    // One extra bit suffices: any overflow past the image edge lands in the negative half.
    always_comb begin
        dr = {{(ROW_W-1){TAP_DR[tap][1]}}, TAP_DR[tap]};
        dc = {{(COL_W-1){TAP_DC[tap][1]}}, TAP_DC[tap]};
`ifdef WINDOW_DILATION_EN
        dr = dil ? {dr[ROW_W-1:0], 1'b0} : dr;
        dc = dil ? {dc[COL_W-1:0], 1'b0} : dc;
`endif
        r = {1'b0, origin[ROW_W+COL_W-1:COL_W]} + dr;
        c = {1'b0, origin[COL_W-1:0]} + dc;
        eff = !r[ROW_W] && !c[COL_W];
        addr = eff ? {depth, r[ROW_W-1:0], c[COL_W-1:0]} : '0;
    end
`ifndef WINDOW_DILATION_EN
    logic unused_dil;
    assign unused_dil = dil;
`endif
endmodule

// File: rtl/window_addr_gen.sv
// window_addr_gen: 3x3 convolution-window address generator with valid/ready and busy/done.
// Optional dilation-2 window enabled by WINDOW_DILATION_EN.
module window_addr_gen
    import win_pkg::*;
#(
    parameter int COL_W  = 3,
    parameter int ROW_W  = 3,
    parameter int DEP_W  = 2,
    parameter int N_ORIG = 4,
    localparam int PIX_W  = ROW_W + COL_W,
    localparam int ADDR_W = DEP_W + PIX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    depth_all,
    input  logic                    dilate,
    input  logic [N_ORIG*PIX_W-1:0] origin_i,
    output logic [ADDR_W-1:0]       addr_o,
    output logic                    eff_o,
    output logic [3:0]              tap_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int ORG_W = N_ORIG > 1 ? $clog2(N_ORIG) : 1;
    localparam logic [ORG_W-1:0] ORG_LAST = ORG_W'(N_ORIG - 1);

    state_e                  state_q, state_d;
    logic [3:0]              tap_q, tap_d, tap_o_q, tap_o_d;
    logic [ORG_W-1:0]        org_q, org_d;
    logic [DEP_W-1:0]        dep_q, dep_d;
    logic [N_ORIG*PIX_W-1:0] orig_q, orig_d;
    logic                    dil_q, dil_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, calc_addr;
    logic                    eff_q, eff_d, calc_eff;
    logic                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [PIX_W-1:0]        cur_orig;
    logic                    tap_wrap, org_wrap;

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        org_d    = org_q;
        dep_d    = dep_q;
        orig_d   = orig_q;
        dil_d    = dil_q;
        tap_wrap = tap_q == TAP_LAST;
        org_wrap = tap_wrap && org_q == ORG_LAST;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                orig_d  = origin_i;
                dil_d   = dilate;
                tap_d   = '0;
                org_d   = '0;
                dep_d   = depth_all ? '0 : '1;
            end
            RUN: if (ready_i) begin
                state_d = org_wrap && dep_q == '1 ? DONE : RUN;
                tap_d   = tap_wrap ? '0 : tap_q + 4'd1;
                org_d   = !tap_wrap ? org_q : org_wrap ? '0 : org_q + 1'b1;
                dep_d   = org_wrap ? dep_q + 1'b1 : dep_q;
            end
            default: state_d = IDLE;
        endcase
        cur_orig = '0;
        for (int k = 0; k < N_ORIG; k++)
            if (org_d == ORG_W'(k)) cur_orig = orig_d[k*PIX_W +: PIX_W];
        valid_d = state_d == RUN;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        addr_d  = valid_d ? calc_addr : '0;
        eff_d   = valid_d && calc_eff;
        tap_o_d = valid_d ? tap_d : '0;
    end

    window_tap_calc #(.COL_W(COL_W), .ROW_W(ROW_W), .DEP_W(DEP_W)) u_calc (
        .origin (cur_orig),
        .tap    (tap_d),
        .depth  (dep_d),
        .dil    (dil_d),
        .addr   (calc_addr),
        .eff    (calc_eff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tap_q   <= '0;
            org_q   <= '0;
            dep_q   <= '0;
            orig_q  <= '0;
            dil_q   <= 1'b0;
            addr_q  <= '0;
            eff_q   <= 1'b0;
            tap_o_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            org_q   <= org_d;
            dep_q   <= dep_d;
            orig_q  <= orig_d;
            dil_q   <= dil_d;
            addr_q  <= addr_d;
            eff_q   <= eff_d;
            tap_o_q <= tap_o_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_o  = addr_q;
    assign eff_o   = eff_q;
    assign tap_o   = tap_o_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
endmodule
